// File: rtl/posit32_encode_pipe.sv
// ============================================================================
// Module   : posit32_encode_pipe
// Brief    : 3-stage valid/ready encoder packing sign/scale/fraction into posit32 (es=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module posit32_encode_pipe #(
    parameter int SCALE_W = 9,
    parameter int FRAC_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [SCALE_W-1:0] in_scale,
    input  logic [FRAC_W-1:0]  in_frac,
    input  logic               in_sticky,
    input  logic               in_zero,
    input  logic               in_nar,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_posit
);

    // Wide enough that a regime shift of up to 31 never drops fraction bits.
    localparam int VW = FRAC_W + 34;
    localparam logic signed [SCALE_W-1:0] K_HI = SCALE_W'(30);
    localparam logic signed [SCALE_W-1:0] K_LO = -SCALE_W'(30);

    logic v1, v2, v3;
    logic rdy1, rdy2, rdy3;

    assign rdy3      = !v3 || out_ready;
    assign rdy2      = !v2 || rdy3;
    assign rdy1      = !v1 || rdy2;
    assign in_ready  = rdy1;
    assign out_valid = v3;

    // ---------------- stage 1: regime length and saturation ----------------
    logic signed [SCALE_W-1:0] k;
    logic                      k_neg, sat_hi, sat_lo;
    logic [4:0]                r_len;

    assign k      = $signed(in_scale) >>> 2;
    assign k_neg  = k[SCALE_W-1];
    assign sat_hi = (k >= K_HI);
    assign sat_lo = (k <= K_LO);
    assign r_len  = (sat_hi || sat_lo) ? 5'd31
                  : (k_neg ? (5'd1 - k[4:0]) : (k[4:0] + 5'd2));

    logic              s1_sign, s1_zero, s1_nar, s1_sat_hi, s1_sat_lo, s1_neg, s1_sticky;
    logic [4:0]        s1_r;
    logic [1:0]        s1_e;
    logic [FRAC_W-1:0] s1_frac;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            s1_sign   <= 1'b0;
            s1_zero   <= 1'b0;
            s1_nar    <= 1'b0;
            s1_sat_hi <= 1'b0;
            s1_sat_lo <= 1'b0;
            s1_neg    <= 1'b0;
            s1_sticky <= 1'b0;
            s1_r      <= '0;
            s1_e      <= '0;
            s1_frac   <= '0;
        end else if (rdy1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sign   <= in_sign;
                s1_zero   <= in_zero;
                s1_nar    <= in_nar;
                s1_sat_hi <= sat_hi;
                s1_sat_lo <= sat_lo;
                s1_neg    <= k_neg;
                s1_sticky <= in_sticky;
                s1_r      <= r_len;
                s1_e      <= in_scale[1:0];
                s1_frac   <= in_frac;
            end
        end
    end

    // ---------------- stage 2: build body, guard, sticky, round decision ----------------
    logic [31:0]   regime;
    logic [VW-1:0] field;
    logic [30:0]   body;
    logic          guard, sticky, rnd;

    assign regime = s1_neg ? (32'h8000_0000 >> (s1_r - 5'd1))
                           : ~(32'hFFFF_FFFF >> (s1_r - 5'd1));
    assign field  = ({s1_e, s1_frac, 32'b0} >> s1_r) | {regime, {(FRAC_W + 2){1'b0}}};
    assign body   = field[VW-1 -: 31];
    assign guard  = field[VW-32];
    assign sticky = (|field[VW-33:0]) | s1_sticky;
    assign rnd    = guard && (body[0] || sticky);

    logic        s2_sign, s2_zero, s2_nar, s2_sat_hi, s2_sat_lo, s2_rnd;
    logic [30:0] s2_body;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2        <= 1'b0;
            s2_sign   <= 1'b0;
            s2_zero   <= 1'b0;
            s2_nar    <= 1'b0;
            s2_sat_hi <= 1'b0;
            s2_sat_lo <= 1'b0;
            s2_rnd    <= 1'b0;
            s2_body   <= '0;
        end else if (rdy2) begin
            v2 <= v1;
            if (v1) begin
                s2_sign   <= s1_sign;
                s2_zero   <= s1_zero;
                s2_nar    <= s1_nar;
                s2_sat_hi <= s1_sat_hi;
                s2_sat_lo <= s1_sat_lo;
                s2_rnd    <= rnd;
                s2_body   <= body;
            end
        end
    end

    // ---------------- stage 3: round add, saturate, specials, negate ----------------
    logic [31:0] sum, mag, result;

    assign sum = {1'b0, s2_body} + {31'b0, s2_rnd};

    always_comb begin
        mag = sum;
        if (s2_sat_hi || sum[31])
            mag = 32'h7FFF_FFFF;
        else if (s2_sat_lo || (sum == 32'd0))
            mag = 32'h0000_0001;

        result = s2_sign ? (-mag) : mag;
        if (s2_nar)
            result = 32'h8000_0000;
        else if (s2_zero)
            result = 32'h0000_0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3        <= 1'b0;
            out_posit <= '0;
        end else if (rdy3) begin
            v3 <= v2;
            if (v2)
                out_posit <= result;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_posit32_encode_pipe.sv
// ============================================================================
// Module   : tb_posit32_encode_pipe
// Brief    : Directed + randomized bench with a bit-stream reference posit encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_posit32_encode_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [8:0]  in_scale = '0;
    logic [31:0] in_frac = '0;
    logic        in_sticky = 1'b0;
    logic        in_zero = 1'b0;
    logic        in_nar = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_posit;

    posit32_encode_pipe #(.SCALE_W(9), .FRAC_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_scale  (in_scale),
        .in_frac   (in_frac),
        .in_sticky (in_sticky),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    int          first_out_cyc = -1;
    bit          last_acc = 1'b0;
    bit          dir_en = 1'b0;
    logic [31:0] dir_exp = '0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: write the posit body out bit by bit, then round and clamp.
    function automatic logic [31:0] ref_posit(bit sign, int scale, logic [31:0] frac,
                                              bit stk, bit zero, bit nar);
        int     k, e;
        bit     bits[$];
        longint body, mag;
        bit     guard, sticky;
        if (nar)  return 32'h8000_0000;
        if (zero) return 32'h0000_0000;
        k = scale >>> 2;
        e = scale - 4 * k;
        if (k >= 30) mag = 64'h7FFF_FFFF;
        else if (k <= -30) mag = 1;
        else begin
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                for (int i = 0; i < -k; i++) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            bits.push_back(e[1]);
            bits.push_back(e[0]);
            for (int i = 31; i >= 0; i--) bits.push_back(frac[i]);
            body = 0;
            for (int i = 0; i < 31; i++) body = body * 2 + longint'(bits[i]);
            guard  = bits[31];
            sticky = stk;
            for (int i = 32; i < bits.size(); i++) sticky |= bits[i];
            mag = body + ((guard && (body[0] || sticky)) ? 1 : 0);
            if (mag > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
            if (mag == 0) mag = 1;
        end
        return sign ? 32'(-mag) : 32'(mag);
    endfunction

    // One clock: sample handshakes at the falling edge, then advance to just after the rise.
    task automatic tick();
        bit          ofire;
        logic [31:0] obs;
        @(negedge clk);
        last_acc = in_valid && in_ready;
        ofire    = out_valid && out_ready;
        obs      = out_posit;
        if (last_acc) begin
            exp_q.push_back(dir_en ? dir_exp
                : ref_posit(in_sign, int'($signed(in_scale)), in_frac, in_sticky, in_zero, in_nar));
            last_acc_cyc = cyc;
        end
        if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
        if (ofire) begin
            if (exp_q.size() == 0) check("spurious_out", 32'(exp_q.size()), 32'd1);
            else check("out_posit", obs, exp_q.pop_front());
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input bit s, input int sc, input logic [31:0] f,
                            input bit st, input bit z, input bit n);
        in_sign   = s;
        in_scale  = 9'(sc);
        in_frac   = f;
        in_sticky = st;
        in_zero   = z;
        in_nar    = n;
    endtask

    task automatic rand_beat();
        int sc;
        sc = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 511) - 256 : $urandom_range(0, 260) - 130;
        set_beat(1'($urandom), sc, $urandom, 1'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
    endtask

    task automatic send(input bit s, input int sc, input logic [31:0] f, input bit st,
                        input bit z, input bit n, input logic [31:0] exp);
        int guard_cnt;
        set_beat(s, sc, f, st, z, n);
        dir_en   = 1'b1;
        dir_exp  = exp;
        in_valid = 1'b1;
        guard_cnt = 0;
        do begin
            tick();
            guard_cnt++;
        end while (!last_acc && guard_cnt < 50);
        if (!last_acc) check("send_timeout", 32'(guard_cnt), 32'd0);
        in_valid = 1'b0;
        dir_en   = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int          acc_cnt, beats;
        bit          have_held;
        logic [31:0] held;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_posit", out_posit, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick();

        // T1 with latency
        first_out_cyc = -1;
        send(1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h4000_0000);
        drain();
        check("latency", 32'(first_out_cyc - last_acc_cyc), 32'd3);
        send(1'b1, 0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hC000_0000);

        // T2, T3, T4 streamed back to back where possible
        send(1'b0, 1,    32'h0, 1'b0, 1'b0, 1'b0, 32'h4800_0000);
        send(1'b0, -1,   32'h0, 1'b0, 1'b0, 1'b0, 32'h3800_0000);
        send(1'b0, 120,  32'h0, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF);
        send(1'b0, 255,  32'h0, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF);
        send(1'b0, -120, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0000_0001);
        send(1'b0, -256, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0000_0001);
        send(1'b1, 120,  32'h0, 1'b0, 1'b0, 1'b0, 32'h8000_0001);
        send(1'b0, 0, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 32'h4000_0000);
        send(1'b0, 0, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 32'h4000_0002);
        send(1'b0, 0, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'h4000_0001);
        send(1'b0, 0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0000);
        send(1'b0, 5, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h0000_0000);
        send(1'b0, 119, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF);
        drain();

        // T5 backpressure: 8 beats, sink stalled for 5 cycles
        out_ready = 1'b0;
        acc_cnt   = 0;
        have_held = 1'b0;
        held      = '0;
        rand_beat();
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (last_acc) begin acc_cnt++; rand_beat(); end
            if (out_valid) begin
                if (have_held) check("stall_stable", out_posit, held);
                else begin held = out_posit; have_held = 1'b1; end
            end
        end
        check("stall_accepts", 32'(acc_cnt), 32'd3);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        beats = 0;
        while (acc_cnt < 8 && beats < 60) begin
            tick();
            beats++;
            if (last_acc) begin acc_cnt++; rand_beat(); end
        end
        in_valid = 1'b0;
        check("stream_accepts", 32'(acc_cnt), 32'd8);
        drain();

        // Randomized traffic with random stalls
        for (int i = 0; i < 600; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_beat();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        drain();

        // T6 reset with 3 beats in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc_cnt   = 0;
        rand_beat();
        for (int i = 0; i < 4; i++) begin
            tick();
            if (last_acc) begin acc_cnt++; rand_beat(); end
        end
        in_valid = 1'b0;
        check("t6_filled", 32'(acc_cnt), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        first_out_cyc = -1;
        send(1'b0, 1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h4800_0000);
        drain();
        check("t6_latency", 32'(first_out_cyc - last_acc_cyc), 32'd3);
        repeat (6) tick();
        check("t6_idle_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
